// File: rtl/spi_master_multi_pkg.sv
// Shared definitions for the multi-mode SPI master: FSM states, mode codes
// ({cpol, cpha}) and the default sclk half-period.
package spi_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, HOLD} spi_state_t;

   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   localparam int DEF_CLK_DIV = 50;

endpackage

// File: rtl/spi_master_multi_sclk_gen.sv
// sclk divider: toggles sclk every CLK_DIV clk cycles while enabled and flags
// the clk cycle on which the next edge lands as leading or trailing.
module spi_sclk_gen #(
   parameter int CLK_DIV = 50
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_idle,
   output logic o_sclk,
   output logic o_lead,
   output logic o_trail
);

   localparam int CW = $clog2(CLK_DIV);

   logic [CW-1:0] r_cnt;
   logic          r_sclk;
   logic          w_tick;

   assign w_tick  = i_en && (r_cnt == CW'(CLK_DIV - 1));
   assign o_lead  = w_tick && (r_sclk == i_idle);
   assign o_trail = w_tick && (r_sclk != i_idle);
   assign o_sclk  = r_sclk;

   // Disabled means parked at the idle level with the counter reloaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_sclk <= 1'b0;
      end else if (!i_en) begin
         r_cnt  <= '0;
         r_sclk <= i_idle;
      end else if (w_tick) begin
         r_cnt  <= '0;
         r_sclk <= ~r_sclk;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_master_multi.sv
// SPI master with runtime CPOL/CPHA, multi-word streaming and several chip selects.
// Define SPI_LOOPBACK_EN to add the loopback input (sample internal mosi instead of miso).
module spi_master_multi
   import spi_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int WORD_W   = 8,
   parameter int NUM_CS   = 2,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int LEN_W    = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 cpol,
   input  logic                 cpha,
   input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cs_sel,
   input  logic [LEN_W-1:0]     xfer_len,
   input  logic [WORD_W-1:0]    tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [WORD_W-1:0]    rx_data,
   output logic                 rx_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 sclk,
   output logic                 mosi,
   input  logic                 miso,
`ifdef SPI_LOOPBACK_EN
   input  logic                 loopback,
`endif
   output logic [NUM_CS-1:0]    cs_n
);

   localparam int EW = $clog2(2 * WORD_W);
   localparam int WW = $clog2(((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD) + 1);

   spi_state_t          r_state;
   logic                r_cpol, r_cpha;
   logic [LEN_W-1:0]    r_left;
   logic [WW-1:0]       r_wait;
   logic [EW-1:0]       r_edge;
   logic [NUM_CS-1:0]   r_cs_n;
   logic                r_mosi, r_rx_valid, r_busy, r_done;
   logic [WORD_W-1:0]   r_rx_data, r_shift, r_rx;
   logic                w_lead, w_trail, w_miso, w_load_acc, w_last, w_drive, w_sample, w_word_end;
   logic [WORD_W-1:0]   w_rx_next;

`ifdef SPI_LOOPBACK_EN
   logic r_loop;
   assign w_miso = r_loop ? r_mosi : miso;
`else
   assign w_miso = miso;
`endif

   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (r_state == SHIFT),
      .i_idle  (r_cpol),
      .o_sclk  (sclk),
      .o_lead  (w_lead),
      .o_trail (w_trail)
   );

   // CPHA=0 puts the MSB out at load time, so its trailing edges shift the next bit.
   assign w_load_acc = (r_state == LOAD) && tx_valid;
   assign w_last     = (r_edge == EW'(2 * WORD_W - 1));
   assign w_drive    = r_cpha ? w_lead : (w_trail && !w_last);
   assign w_sample   = r_cpha ? w_trail : w_lead;
   assign w_word_end = w_trail && w_last;
   assign w_rx_next  = {r_rx[WORD_W-2:0], w_miso};

   assign tx_ready = (r_state == LOAD);
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign busy     = r_busy;
   assign done     = r_done;
   assign mosi     = r_mosi;
   assign cs_n     = r_cs_n;

   always_ff @(posedge clk) begin
      if (w_load_acc)   r_shift <= tx_data;
      else if (w_drive) r_shift <= r_shift << 1;
      if (w_sample)     r_rx <= w_rx_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cpol     <= 1'b0;
         r_cpha     <= 1'b0;
         r_left     <= '0;
         r_wait     <= '0;
         r_edge     <= '0;
         r_cs_n     <= '1;
         r_mosi     <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
`ifdef SPI_LOOPBACK_EN
         r_loop     <= 1'b0;
`endif
      end else begin
         r_rx_valid <= 1'b0;
         r_done     <= 1'b0;
         if (w_load_acc && !r_cpha) r_mosi <= tx_data[WORD_W-1];
         else if (w_drive)          r_mosi <= r_cpha ? r_shift[WORD_W-1] : r_shift[WORD_W-2];
         if (w_lead || w_trail)     r_edge <= r_edge + 1'b1;

         case (r_state)
            IDLE: begin
               r_cpol <= cpol;
               if (start) begin
                  if (xfer_len == '0 || int'(cs_sel) >= NUM_CS) begin
                     r_done <= 1'b1;
                  end else begin
                     r_cpha <= cpha;
                     r_left <= xfer_len;
                     r_busy <= 1'b1;
                     r_wait <= '0;
`ifdef SPI_LOOPBACK_EN
                     r_loop <= loopback;
`endif
                     for (int i = 0; i < NUM_CS; i++) r_cs_n[i] <= (i != int'(cs_sel));
                     r_state <= SETUP;
                  end
               end
            end
            SETUP: begin
               if (r_wait == WW'(CS_SETUP - 1)) begin
                  r_wait  <= '0;
                  r_state <= LOAD;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            LOAD: begin
               if (tx_valid) begin
                  r_edge  <= '0;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (w_word_end) begin
                  r_rx_data  <= r_cpha ? w_rx_next : r_rx;
                  r_rx_valid <= 1'b1;
                  r_left     <= r_left - 1'b1;
                  r_state    <= (r_left == LEN_W'(1)) ? HOLD : LOAD;
               end
            end
            HOLD: begin
               if (r_wait == WW'(CS_HOLD - 1)) begin
                  r_wait  <= '0;
                  r_cs_n  <= '1;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: a behavioural SPI slave supplies reply words and
// captures mosi; transactions come from a vector table plus random ones.
`timescale 1ns/1ps
module tb_spi_master_multi;
   import spi_pkg::*;

   localparam int W = 8, NCS = 3, LW = 4, CD = 2;

   logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0, cpol = 1'b0, cpha = 1'b0;
   logic [1:0]      cs_sel = '0;
   logic [LW-1:0]   xfer_len = '0;
   logic [W-1:0]    tx_data = '0;
   logic            tx_valid = 1'b0;
   logic            tx_ready, rx_valid, busy, done, sclk, mosi;
   logic            miso = 1'b0;
   logic [W-1:0]    rx_data;
   logic [NCS-1:0]  cs_n;
`ifdef SPI_LOOPBACK_EN
   logic            loopback = 1'b0;
`endif

   spi_master_multi #(.CLK_DIV(CD), .WORD_W(W), .NUM_CS(NCS), .CS_SETUP(2), .CS_HOLD(2), .LEN_W(LW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cpol(cpol), .cpha(cpha), .cs_sel(cs_sel),
      .xfer_len(xfer_len), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done), .sclk(sclk),
      .mosi(mosi), .miso(miso),
`ifdef SPI_LOOPBACK_EN
      .loopback(loopback),
`endif
      .cs_n(cs_n));

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]      mode;
      logic [1:0]      cs;
      int              len;
      logic [2:0][7:0] tx, reply, exp_rx;
      int              stall_at, stall;
      logic            lb;
   } xfer_t;

   int n_vec = 0, n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic xfer_t mk(logic [1:0] mode, logic [1:0] cs, int len, logic [23:0] tx,
                                logic [23:0] rp, logic [23:0] ex, int sa, int st, logic lb);
      xfer_t v;
      v.mode = mode; v.cs = cs; v.len = len; v.tx = tx; v.reply = rp; v.exp_rx = ex;
      v.stall_at = sa; v.stall = st; v.lb = lb;
      return v;
   endfunction

   // Slave/monitor state, reset by each transaction.
   logic       m_cpol = 1'b0, m_cpha = 1'b0, m_lb = 1'b0, s_prev = 1'b0;
   logic [7:0] s_reply[$], s_mosi_q[$], rx_q[$];
   logic [7:0] s_cur = '0, s_tmp;
   logic [2:0] cs_seen = '0;
   int         s_edge = -1, s_bits = 0, lead_cnt = 0, done_cnt = 0, bad_cs = 0;

   // The slave counts sclk edges while selected; the master samples bit k of the
   // stream at edge 2k+cpha, so miso always carries bit s_bits between edges.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (rx_valid) rx_q.push_back(rx_data);
      cs_seen |= ~cs_n;
      if ($countones(~cs_n) > 1) bad_cs++;
      if (&cs_n) begin
         s_edge = -1;
         s_bits = 0;
      end else if (sclk !== s_prev) begin
         s_edge++;
         if (sclk !== m_cpol) lead_cnt++;
         if ((s_edge % 2) == int'(m_cpha)) begin
            s_cur = {s_cur[6:0], mosi};
            s_bits++;
            if (s_bits % 8 == 0) s_mosi_q.push_back(s_cur);
         end
      end
      s_prev = sclk;
      if (m_lb || (s_bits / 8) >= s_reply.size()) miso = 1'b0;
      else begin
         s_tmp = s_reply[s_bits / 8];
         miso  = s_tmp[7 - s_bits % 8];
      end
   end

   task automatic clear_mon();
      rx_q.delete(); s_mosi_q.delete();
      lead_cnt = 0; done_cnt = 0; bad_cs = 0; cs_seen = '0;
   endtask

   task automatic wait_ready(input string tag);
      int t = 0;
      while (!tx_ready && t < 400) begin @(posedge clk); #1; t++; end
      chk({tag, " tx_ready wait"}, 32'(t < 400), 1);
   endtask

   task automatic run_xfer(input string tag, input xfer_t v);
      int   t, idle_viol;
      logic [7:0] a;
      clear_mon();
      s_reply.delete();
      for (int i = 0; i < v.len; i++) s_reply.push_back(v.reply[i]);
      m_cpol = v.mode[1]; m_cpha = v.mode[0]; m_lb = v.lb; idle_viol = 0;
      cpol = v.mode[1]; cpha = v.mode[0]; cs_sel = v.cs; xfer_len = LW'(v.len);
`ifdef SPI_LOOPBACK_EN
      loopback = v.lb;
`endif
      repeat (4) @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      // A second start and altered config while busy must be ignored.
      cpol = ~v.mode[1]; cpha = ~v.mode[0]; cs_sel = v.cs + 2'd1; xfer_len = '0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < v.len; i++) begin
         if (i == v.stall_at && v.stall > 0) begin
            wait_ready(tag);
            repeat (v.stall) begin
               @(posedge clk); #1;
               if (sclk !== v.mode[1]) idle_viol++;
            end
         end
         tx_data = v.tx[i]; tx_valid = 1'b1;
         wait_ready(tag);
         @(posedge clk); #1;
         tx_valid = 1'b0;
      end
      cpol = v.mode[1]; cpha = v.mode[0]; cs_sel = v.cs; xfer_len = LW'(v.len);
      t = 0;
      while (done_cnt == 0 && t < 1000) begin @(posedge clk); #1; t++; end
      chk({tag, " done timeout"}, 32'(t < 1000), 1);
      chk({tag, " sclk idle after"}, 32'(sclk), 32'(v.mode[1]));
      repeat (4) @(posedge clk); #1;
      chk({tag, " done count"}, done_cnt, 1);
      chk({tag, " rx count"}, rx_q.size(), v.len);
      for (int i = 0; i < v.len; i++) begin
         a = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         chk($sformatf("%s rx%0d", tag, i), 32'(a), 32'(v.exp_rx[i]));
         a = (i < s_mosi_q.size()) ? s_mosi_q[i] : 8'hxx;
         chk($sformatf("%s mosi%0d", tag, i), 32'(a), 32'(v.tx[i]));
      end
      chk({tag, " leading edges"}, lead_cnt, v.len * 8);
      chk({tag, " cs_n selected"}, 32'(cs_seen), 32'(3'b001 << v.cs));
      chk({tag, " cs_n overlap"}, bad_cs, 0);
      chk({tag, " sclk during stall"}, idle_viol, 0);
      chk({tag, " busy end"}, 32'(busy), 0);
      chk({tag, " cs_n end"}, 32'(cs_n), 32'(3'b111));
   endtask

   task automatic bad_start(input string tag, input logic [1:0] cs, input logic [LW-1:0] len);
      logic s;
      clear_mon();
      cs_sel = cs; xfer_len = len;
      @(posedge clk); #1;
      s = sclk;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, " done pulse"}, 32'(done), 1);
      chk({tag, " busy"}, 32'(busy), 0);
      repeat (3) @(posedge clk); #1;
      chk({tag, " done once"}, done_cnt, 1);
      chk({tag, " cs_n idle"}, 32'(cs_seen), 0);
      chk({tag, " sclk static"}, 32'(sclk), 32'(s));
      chk({tag, " no tx_ready"}, 32'(tx_ready), 0);
   endtask

   xfer_t tbl[4];
   xfer_t rv;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, limit 1000000 ns");
      $fatal(1);
   end

   initial begin
      tbl[0] = mk(MODE0, 2'd0, 1, 24'h00000F, 24'h0000E5, 24'h0000E5, 0, 0, 1'b0);
      tbl[1] = mk(MODE3, 2'd1, 3, 24'hC3B2A1, 24'hB2A100, 24'hB2A100, 0, 0, 1'b0);
      tbl[2] = mk(MODE1, 2'd0, 2, 24'h00963C, 24'h00C75A, 24'h00C75A, 1, 20, 1'b0);
      tbl[3] = mk(MODE2, 2'd2, 2, 24'h0000FF, 24'h007E81, 24'h007E81, 0, 5, 1'b0);

      repeat (3) @(posedge clk); #1;
      chk("reset cs_n", 32'(cs_n), 32'(3'b111));
      chk("reset sclk", 32'(sclk), 0);
      chk("reset mosi", 32'(mosi), 0);
      chk("reset busy", 32'(busy), 0);
      chk("reset done", 32'(done), 0);
      chk("reset rx_valid", 32'(rx_valid), 0);
      chk("reset rx_data", 32'(rx_data), 0);
      chk("reset tx_ready", 32'(tx_ready), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) run_xfer($sformatf("vec%0d", i), tbl[i]);

      bad_start("len0", 2'd0, 4'd0);
      bad_start("cs3", 2'd3, 4'd1);

      // Reset mid-word in mode 2, then a clean transaction.
      clear_mon();
      m_cpol = 1'b1; m_cpha = 1'b0; m_lb = 1'b0;
      cpol = 1'b1; cpha = 1'b0; cs_sel = 2'd1; xfer_len = 4'd1;
      repeat (4) @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      tx_data = 8'h99; tx_valid = 1'b1;
      wait_ready("rst");
      @(posedge clk); #1;
      tx_valid = 1'b0;
      for (int t = 0; t < 200 && lead_cnt < 3; t++) begin @(posedge clk); #1; end
      chk("rst reached shift", 32'(lead_cnt >= 3), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst cs_n", 32'(cs_n), 32'(3'b111));
      chk("rst busy", 32'(busy), 0);
      chk("rst sclk", 32'(sclk), 0);
      chk("rst tx_ready", 32'(tx_ready), 0);
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b1;
      run_xfer("after_rst", tbl[0]);

`ifdef SPI_LOOPBACK_EN
      run_xfer("loopback", mk(MODE0, 2'd1, 1, 24'h00005A, 24'h000000, 24'h00005A, 0, 0, 1'b1));
`endif

      for (int r = 0; r < 16; r++) begin
         rv.mode = 2'($urandom_range(0, 3));
         rv.cs   = 2'($urandom_range(0, NCS - 1));
         rv.len  = $urandom_range(1, 3);
         for (int i = 0; i < 3; i++) begin
            rv.tx[i]    = 8'($urandom);
            rv.reply[i] = 8'($urandom);
         end
         rv.lb       = 1'b0;
         rv.exp_rx   = rv.reply;
         rv.stall_at = $urandom_range(0, rv.len - 1);
         rv.stall    = $urandom_range(0, 12);
         run_xfer($sformatf("rand%0d", r), rv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
